sm_reg_dump: RTL and testbench

//  Initiator side of the CPU register debug read port (regAddr -> regData).
//  On a start pulse, walks regAddr over FIRST..LAST and waits SETTLE cycles per address.

---
 rtl/sm_reg_dump.sv | 141 ++++++++++++++
 tb/tb_sm_reg_dump.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_reg_dump.sv
// Debug register dumper: walks the CPU debug read port over FIRST..LAST,
// captures each 32-bit word after a settle delay and streams it out as four
// bytes (MSB first) on a valid/ready byte interface.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no dump active; waits for start, regAddr holds last value
// S_WAIT | regAddr driven, counting settle cycles before sampling regData
// S_SEND | presenting the captured word byte by byte, stalls on !txReady
module sm_reg_dump #(
   parameter int ADDR_W = 5,
   parameter int FIRST  = 0,
   parameter int LAST   = 31,
   parameter int SETTLE = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] regAddr,
   input  logic [31:0]       regData,
   output logic [7:0]        txData,
   output logic              txValid,
   input  logic              txReady
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_SEND = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       word_q, word_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        txd_q, txd_d;
   logic              txv_q, txv_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [7:0]        next_byte;

   // Byte that follows the one currently presented (idx 0 is already bits 31:24).
   always_comb begin
      case (idx_q)
         2'd0:    next_byte = word_q[23:16];
         2'd1:    next_byte = word_q[15:8];
         default: next_byte = word_q[7:0];
      endcase
   end

   // Next-state and registered-output logic for the dump sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      word_d  = word_q;
      addr_d  = addr_q;
      txd_d   = txd_q;
      txv_d   = txv_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = ADDR_W'(FIRST);
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(SETTLE - 1)) begin
               word_d  = regData;
               txd_d   = regData[31:24];
               txv_d   = 1'b1;
               idx_d   = 2'd0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (txReady) begin
               if (idx_q == 2'd3) begin
                  txv_d = 1'b0;
                  // LAST is checked before incrementing so the address never wraps.
                  if (addr_q == ADDR_W'(LAST)) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     addr_d  = addr_q + 1'b1;
                     cnt_d   = '0;
                     state_d = S_WAIT;
                  end
               end else begin
                  idx_d = idx_q + 2'd1;
                  txd_d = next_byte;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any dump in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         word_q  <= 32'd0;
         addr_q  <= '0;
         txd_q   <= 8'd0;
         txv_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         txd_q   <= txd_d;
         txv_q   <= txv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign regAddr = addr_q;
   assign txData  = txd_q;
   assign txValid = txv_q;

endmodule

// File: tb/tb_sm_reg_dump.sv
// Bench for sm_reg_dump: two instances (short dump with SETTLE=2, full
// 32-register dump with SETTLE=1) checked against an arithmetic model of
// the expected byte stream, settle gaps, stalls and done pulses.
module tb_sm_reg_dump;

   localparam int A_FIRST = 0, A_LAST = 1,  A_SETTLE = 2;
   localparam int B_FIRST = 0, B_LAST = 31, B_SETTLE = 1;
   localparam int A_TOT = 4 * (A_LAST - A_FIRST + 1);
   localparam int B_TOT = 4 * (B_LAST - B_FIRST + 1);

   typedef struct packed {
      int         idx;
      int         dones;
      int         gap;
      logic       stall;
      logic [7:0] stall_d;
      logic       prev_v;
      logic       prev_done;
   } mon_t;

   logic        clk, rst_n;
   logic        start_a, busy_a, done_a, txv_a, txr_a;
   logic [4:0]  addr_a;
   logic [31:0] rdata_a;
   logic [7:0]  txd_a;
   logic        start_b, busy_b, done_b, txv_b, txr_b;
   logic [4:0]  addr_b;
   logic [31:0] rdata_b;
   logic [7:0]  txd_b;
   logic [31:0] noise;
   int          n_cmp, n_err;
   int          rmode_a, rmode_b, pi;
   logic [5:0]  pat;
   mon_t        ma, mb;

   // Register model; while a byte is on the bus regData is scrambled so a late capture shows.
   assign rdata_a = txv_a ? noise : 32'h11223344 + {27'd0, addr_a};
   assign rdata_b = txv_b ? noise : {4{3'b000, addr_b}};

   sm_reg_dump #(.ADDR_W(5), .FIRST(A_FIRST), .LAST(A_LAST), .SETTLE(A_SETTLE)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
      .regAddr(addr_a), .regData(rdata_a), .txData(txd_a), .txValid(txv_a), .txReady(txr_a)
   );

   sm_reg_dump #(.ADDR_W(5), .FIRST(B_FIRST), .LAST(B_LAST), .SETTLE(B_SETTLE)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
      .regAddr(addr_b), .regData(rdata_b), .txData(txd_b), .txValid(txv_b), .txReady(txr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int id, input int idx);
      int          a;
      logic [31:0] w;
      if (id == 0) begin
         a = A_FIRST + (idx % A_TOT) / 4;
         w = 32'h11223344 + 32'(a);
      end else begin
         a = B_FIRST + (idx % B_TOT) / 4;
         w = {4{8'(a)}};
      end
      return 8'(w >> (8 * (3 - idx % 4)));
   endfunction

   // Observe one instance at a negedge; txr is the ready value for the coming edge.
   task automatic observe(input int id, input int tot, input int first, input int last,
                          input int settle, input logic busy, input logic done,
                          input logic [4:0] addr, input logic [7:0] txd, input logic txv,
                          input logic txr, inout mon_t m);
      if (m.stall) begin
         check("stall_valid", 32'(txv), 32'd1);
         check("stall_data", 32'(txd), 32'(m.stall_d));
      end
      if (txv) check("busy_with_valid", 32'(busy), 32'd1);
      if (txv && !m.prev_v) begin
         check("settle_gap", 32'(m.gap), 32'(settle));
         check("word_addr", 32'(addr), 32'(first + (m.idx % tot) / 4));
      end
      if (done) begin
         check("done_width", 32'(m.prev_done), 32'd0);
         check("done_bytes", 32'(m.idx - m.dones * tot), 32'(tot));
         check("done_addr", 32'(addr), 32'(last));
         check("done_busy", 32'(busy), 32'd0);
         m.dones++;
      end
      if (txv && txr) begin
         check("byte", 32'(txd), 32'(exp_byte(id, m.idx)));
         m.idx++;
      end
      if (txv || !busy) m.gap = 0;
      else              m.gap++;
      m.stall     = txv && !txr;
      m.stall_d   = txd;
      m.prev_v    = txv;
      m.prev_done = done;
   endtask

   function automatic logic pick_ready(input int mode);
      if (mode == 0) return 1'b1;
      if (mode == 1) return pat[pi % 6];
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic cycle();
      @(negedge clk);
      noise = $urandom;
      pi++;
      txr_a = pick_ready(rmode_a);
      txr_b = pick_ready(rmode_b);
      observe(0, A_TOT, A_FIRST, A_LAST, A_SETTLE, busy_a, done_a, addr_a, txd_a, txv_a, txr_a, ma);
      observe(1, B_TOT, B_FIRST, B_LAST, B_SETTLE, busy_b, done_b, addr_b, txd_b, txv_b, txr_b, mb);
   endtask

   task automatic run_until(input int which, input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (which == 0 && ma.dones >= target) break;
         if (which == 1 && mb.dones >= target) break;
         cycle();
      end
   endtask

   task automatic check_zero_a(input string tag);
      check({tag, "_busy"}, 32'(busy_a), 32'd0);
      check({tag, "_done"}, 32'(done_a), 32'd0);
      check({tag, "_valid"}, 32'(txv_a), 32'd0);
      check({tag, "_data"}, 32'(txd_a), 32'd0);
      check({tag, "_addr"}, 32'(addr_a), 32'd0);
   endtask

   task automatic dump_a(input string tag, input int mode);
      ma = '0;
      rmode_a = mode;
      start_a = 1'b1;
      cycle();
      start_a = 1'b0;
      run_until(0, 1, 400);
      check({tag, "_ndone"}, 32'(ma.dones), 32'd1);
      check({tag, "_nbytes"}, 32'(ma.idx), 32'(A_TOT));
      repeat (4) cycle();
      check({tag, "_idle_busy"}, 32'(busy_a), 32'd0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; pi = 0;
      pat = 6'b101001;
      rmode_a = 0; rmode_b = 0;
      start_a = 1'b0; start_b = 1'b0;
      txr_a = 1'b0; txr_b = 1'b0;
      noise = 32'd0;
      ma = '0; mb = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_zero_a("reset");
      check("reset_b_valid", 32'(txv_b), 32'd0);
      check("reset_b_addr", 32'(addr_b), 32'd0);
      rst_n = 1'b1;

      // full-speed, then the 1,0,0,1,0,1 ready pattern, then random ready
      dump_a("fast", 0);
      dump_a("pattern", 1);
      dump_a("random", 2);

      // second start pulse 3 cycles into the dump is ignored
      ma = '0;
      rmode_a = 2;
      start_a = 1'b1;
      cycle();
      start_a = 1'b0;
      repeat (2) cycle();
      start_a = 1'b1;
      cycle();
      start_a = 1'b0;
      run_until(0, 1, 400);
      repeat (12) cycle();
      check("restart_ignored_ndone", 32'(ma.dones), 32'd1);
      check("restart_ignored_nbytes", 32'(ma.idx), 32'(A_TOT));

      // reset during the 2nd byte of word 1 aborts, then a fresh dump replays
      ma = '0;
      rmode_a = 0;
      start_a = 1'b1;
      cycle();
      start_a = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (ma.idx >= 5) break;
         cycle();
      end
      check("abort_point", 32'(ma.idx), 32'd5);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_zero_a("abort");
      check("abort_no_done", 32'(ma.dones), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dump_a("replay", 2);

      // start held high: new dump on the first IDLE edge after done
      ma = '0;
      rmode_a = 0;
      start_a = 1'b1;
      cycle();
      run_until(0, 1, 400);
      cycle();
      check("held_restart_busy", 32'(busy_a), 32'd1);
      start_a = 1'b0;
      run_until(0, 2, 400);
      check("held_ndone", 32'(ma.dones), 32'd2);
      check("held_nbytes", 32'(ma.idx), 32'(2 * A_TOT));

      // full 0..31 dump, SETTLE=1, ready always high then random
      mb = '0;
      rmode_b = 0;
      start_b = 1'b1;
      cycle();
      start_b = 1'b0;
      run_until(1, 1, 2000);
      check("full_fast_ndone", 32'(mb.dones), 32'd1);
      check("full_fast_nbytes", 32'(mb.idx), 32'(B_TOT));
      mb = '0;
      rmode_b = 2;
      start_b = 1'b1;
      cycle();
      start_b = 1'b0;
      run_until(1, 1, 4000);
      check("full_rand_ndone", 32'(mb.dones), 32'd1);
      check("full_rand_nbytes", 32'(mb.idx), 32'(B_TOT));
      repeat (6) cycle();
      check("no_wrap_addr", 32'(addr_b), 32'(B_LAST));
      check("no_wrap_busy", 32'(busy_b), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
